hazard_control_unit: RTL and testbench

- Pipeline sequencer for the 5-stage core; companion to the forwarding unit. It detects and resolves every hazard that forwarding cannot cover:
  - load-use stalls, with a load-to-store exemption that relies on MEM-to-MEM forwarding,
  - control redirects resolved in EX,
  - data-memory wait freezes,
  - instruction-memory wait bubbles.
- Drives the PC and pipeline-register write-enable and flush controls; keeps a memory-wait watchdog and saturating stall/flush performance counters.

---
 rtl/core_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/hazard_control_unit.sv | 126 ++++++++++++
 tb/tb_hazard_control_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the core's pipeline control: hazard FSM states and
// the architectural zero register index.
package core_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LU_STALL = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'h00;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (en && count != '1)
            count <= count + W'(1);
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: resolves load-use, redirect and memory-wait hazards
// the forwarding unit cannot cover, with watchdog and perf counters.
module hazard_control_unit
    import core_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF2ID_RS1,
    input  logic [4:0]       IF2ID_RS2,
    input  logic             IF2ID_Uses_RS1,
    input  logic             IF2ID_Uses_RS2,
    input  logic             IF2ID_IsStore,
    input  logic             ID2EX_MemRead,
    input  logic [4:0]       ID2EX_RD1,
    input  logic             EX_BranchTaken,
    input  logic             Dmem_Req,
    input  logic             Dmem_Ready,
    input  logic             Imem_Ready,
    output logic             PC_Write,
    output logic             IF2ID_Write,
    output logic             IF2ID_Flush,
    output logic             ID2EX_Write,
    output logic             ID2EX_Flush,
    output logic             EX2Mem_Write,
    output logic             Mem2WB_Flush,
    output logic             Mem_Timeout,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count,
    output logic [1:0]       Hz_State
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

    hz_state_t       state, state_nxt;
    logic [TO_W-1:0] wd_cnt;
    logic            lu_rs1, lu_rs2, load_use, mem_stall;
    logic            stall_inc, flush_inc;

    // A load feeding only store data is covered by MEM-to-MEM forwarding.
    assign lu_rs1    = ID2EX_MemRead && ID2EX_RD1 != REG_ZERO && IF2ID_Uses_RS1
                       && ID2EX_RD1 == IF2ID_RS1;
    assign lu_rs2    = ID2EX_MemRead && ID2EX_RD1 != REG_ZERO && IF2ID_Uses_RS2
                       && ID2EX_RD1 == IF2ID_RS2 && !IF2ID_IsStore;
    assign load_use  = lu_rs1 || lu_rs2;
    assign mem_stall = Dmem_Req && !Dmem_Ready;
    assign Hz_State  = state;

    always_ff @(posedge clk) begin
        if (rst)
            state <= HZ_RUN;
        else
            state <= state_nxt;
    end

    // RUN and MEM_WAIT decode identically; MEM_WAIT only records the freeze.
    always_comb begin
        PC_Write     = 1'b1;
        IF2ID_Write  = 1'b1;
        IF2ID_Flush  = 1'b0;
        ID2EX_Write  = 1'b1;
        ID2EX_Flush  = 1'b0;
        EX2Mem_Write = 1'b1;
        Mem2WB_Flush = 1'b0;
        state_nxt    = HZ_RUN;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (rst) begin
            state_nxt = HZ_RUN;
        end else if (mem_stall) begin
            PC_Write     = 1'b0;
            IF2ID_Write  = 1'b0;
            ID2EX_Write  = 1'b0;
            EX2Mem_Write = 1'b0;
            Mem2WB_Flush = 1'b1;
            stall_inc    = 1'b1;
            state_nxt    = HZ_MEM_WAIT;
        end else if (EX_BranchTaken) begin
            IF2ID_Flush = 1'b1;
            ID2EX_Flush = 1'b1;
            flush_inc   = 1'b1;
        end else if (load_use && state != HZ_LU_STALL) begin
            PC_Write    = 1'b0;
            IF2ID_Write = 1'b0;
            ID2EX_Flush = 1'b1;
            stall_inc   = 1'b1;
            state_nxt   = HZ_LU_STALL;
        end else if (!Imem_Ready) begin
            PC_Write    = 1'b0;
            IF2ID_Flush = 1'b1;
        end
    end

    // Watchdog counts consecutive frozen cycles; the error flag is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt      <= '0;
            Mem_Timeout <= 1'b0;
        end else if (mem_stall) begin
            if (wd_cnt != '1)
                wd_cnt <= wd_cnt + TO_W'(1);
            if (MEM_TIMEOUT != 0 && wd_cnt == TO_LIM - TO_W'(1))
                Mem_Timeout <= 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (stall_inc),
        .count (Stall_Count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (flush_inc),
        .count (Flush_Count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench: directed hazard scenarios with literal checks plus a
// per-cycle comparison against a rule-level model of the sequencer.
module tb_hazard_control_unit;

    localparam int CNT_W = 32;
    localparam int TO_W  = 8;
    localparam int MT    = 4;

    logic             clk, rst;
    logic [4:0]       rs1, rs2, rd1;
    logic             uses1, uses2, is_store, mem_read, br, dreq, drdy, irdy;
    logic             pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f, mto;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [1:0]       hz;

    int tests = 0;
    int fails = 0;

    hazard_control_unit #(.CNT_W(CNT_W), .TO_W(TO_W), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst),
        .IF2ID_RS1(rs1), .IF2ID_RS2(rs2),
        .IF2ID_Uses_RS1(uses1), .IF2ID_Uses_RS2(uses2), .IF2ID_IsStore(is_store),
        .ID2EX_MemRead(mem_read), .ID2EX_RD1(rd1), .EX_BranchTaken(br),
        .Dmem_Req(dreq), .Dmem_Ready(drdy), .Imem_Ready(irdy),
        .PC_Write(pc_w), .IF2ID_Write(ifid_w), .IF2ID_Flush(ifid_f),
        .ID2EX_Write(idex_w), .ID2EX_Flush(idex_f), .EX2Mem_Write(exmem_w),
        .Mem2WB_Flush(memwb_f), .Mem_Timeout(mto),
        .Stall_Count(stall_cnt), .Flush_Count(flush_cnt), .Hz_State(hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Event classes, in priority order, decided from the hazard rules.
    typedef enum int {EV_NONE, EV_FREEZE, EV_REDIRECT, EV_LOADUSE, EV_BUBBLE, EV_RESET} ev_t;

    int     m_state = 0;   // 0 run, 1 one-cycle load-use follow-up, 2 frozen
    longint m_stall = 0, m_flush = 0;
    int     m_wd = 0;
    bit     m_to = 0;

    function automatic ev_t classify();
        bit hit1, hit2;
        hit1 = mem_read && rd1 != 0 && uses1 && rd1 == rs1;
        hit2 = mem_read && rd1 != 0 && uses2 && rd1 == rs2 && !is_store;
        if (rst)                                   return EV_RESET;
        if (dreq && !drdy)                         return EV_FREEZE;
        if (br)                                    return EV_REDIRECT;
        if ((hit1 || hit2) && m_state != 1)        return EV_LOADUSE;
        if (!irdy)                                 return EV_BUBBLE;
        return EV_NONE;
    endfunction

    // {PC, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, MEMWB_F}
    function automatic logic [6:0] expect_ctl(ev_t ev);
        case (ev)
            EV_FREEZE:   return 7'b0000001;
            EV_REDIRECT: return 7'b1111110;
            EV_LOADUSE:  return 7'b0001110;
            EV_BUBBLE:   return 7'b0111010;
            default:     return 7'b1101010;
        endcase
    endfunction

    function automatic longint sat_inc(longint v);
        longint lim = (longint'(1) << CNT_W) - 1;
        return (v >= lim) ? lim : v + 1;
    endfunction

    initial begin : compare
        ev_t        ev;
        logic [6:0] e;
        forever begin
            @(posedge clk);
            ev = classify();
            if (ev == EV_RESET) begin
                m_state = 0; m_stall = 0; m_flush = 0; m_wd = 0; m_to = 0;
            end else begin
                if (ev == EV_FREEZE || ev == EV_LOADUSE) m_stall = sat_inc(m_stall);
                if (ev == EV_REDIRECT) m_flush = sat_inc(m_flush);
                m_wd = (ev == EV_FREEZE) ? m_wd + 1 : 0;
                if (MT != 0 && m_wd >= MT) m_to = 1;
                m_state = (ev == EV_FREEZE) ? 2 : (ev == EV_LOADUSE) ? 1 : 0;
            end
            @(negedge clk);
            e = expect_ctl(classify());
            chk("PC_Write",     pc_w,    e[6]);
            chk("IF2ID_Write",  ifid_w,  e[5]);
            chk("IF2ID_Flush",  ifid_f,  e[4]);
            chk("ID2EX_Write",  idex_w,  e[3]);
            chk("ID2EX_Flush",  idex_f,  e[2]);
            chk("EX2Mem_Write", exmem_w, e[1]);
            chk("Mem2WB_Flush", memwb_f, e[0]);
            chk("Hz_State",     hz,      m_state);
            chk("Stall_Count",  stall_cnt, m_stall);
            chk("Flush_Count",  flush_cnt, m_flush);
            chk("Mem_Timeout",  mto,     m_to);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        rs1 = 0; rs2 = 0; rd1 = 0; uses1 = 0; uses2 = 0; is_store = 0;
        mem_read = 0; br = 0; dreq = 0; drdy = 1; irdy = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin : drive
        idle();
        rst = 1;
        tick(); tick();
        settle();
        chk("rst_enables", {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, memwb_f}, 7'b1111000);
        rst = 0;
        tick();
        chk("rst_state", hz, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_to", mto, 0);

        // load-use on rs1
        mem_read = 1; rd1 = 5; rs1 = 5; uses1 = 1;
        settle();
        chk("lu_pc", pc_w, 0);
        chk("lu_ifid_w", ifid_w, 0);
        chk("lu_idex_f", idex_f, 1);
        tick();
        idle();
        settle();
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("lu_state", hz, 1);
        chk("lu_follow_pc", pc_w, 1);
        tick();
        chk("lu_back_run", hz, 0);

        // load feeding store data: no stall; same without store: stall
        mem_read = 1; rd1 = 7; rs2 = 7; uses2 = 1; is_store = 1;
        settle();
        chk("st_pc", pc_w, 1);
        chk("st_ifid_w", ifid_w, 1);
        tick();
        chk("st_no_count", stall_cnt, 1);
        is_store = 0;
        settle();
        chk("nost_pc", pc_w, 0);
        tick();
        idle();
        chk("nost_cnt", stall_cnt, 2);
        tick();

        // x0 destination never stalls
        mem_read = 1; rd1 = 0; rs1 = 0; uses1 = 1;
        settle();
        chk("x0_pc", pc_w, 1);
        tick();
        chk("x0_cnt", stall_cnt, 2);

        // branch squashes a simultaneous load-use
        mem_read = 1; rd1 = 5; rs1 = 5; uses1 = 1; br = 1;
        settle();
        chk("br_pc", pc_w, 1);
        chk("br_ifid_f", ifid_f, 1);
        chk("br_idex_f", idex_f, 1);
        tick();
        idle();
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 2);
        chk("br_state", hz, 0);

        // fetch not ready: bubble into IF/ID only
        irdy = 0;
        settle();
        chk("im_pc", pc_w, 0);
        chk("im_ifid_f", ifid_f, 1);
        chk("im_idex_w", idex_w, 1);
        tick();
        idle();

        // memory wait for 6 cycles, watchdog at 4
        dreq = 1; drdy = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("mw_enables", {pc_w, ifid_w, idex_w, exmem_w}, 0);
            chk("mw_memwb_f", memwb_f, 1);
            tick();
            chk("mw_state", hz, 2);
            chk("mw_to", mto, (i >= 3) ? 1 : 0);
        end
        chk("mw_stall_cnt", stall_cnt, 8);
        // release with a load-use held in the frozen stages
        drdy = 1; mem_read = 1; rd1 = 5; rs1 = 5; uses1 = 1;
        settle();
        chk("rel_pc", pc_w, 0);
        chk("rel_exmem_w", exmem_w, 1);
        tick();
        idle();
        dreq = 0;
        chk("rel_state", hz, 1);
        chk("rel_stall_cnt", stall_cnt, 9);
        chk("rel_to_sticky", mto, 1);
        tick();

        // reset in the middle of a freeze
        dreq = 1; drdy = 0;
        tick(); tick();
        rst = 1;
        settle();
        chk("rstmw_pc", pc_w, 1);
        chk("rstmw_memwb_f", memwb_f, 0);
        tick();
        rst = 0;
        idle();
        settle();
        chk("rstmw_state", hz, 0);
        chk("rstmw_stall", stall_cnt, 0);
        chk("rstmw_flush", flush_cnt, 0);
        chk("rstmw_to", mto, 0);
        chk("rstmw_pc_after", pc_w, 1);
        tick();

        // mixed vectors over a small register range, checked by the model
        for (int i = 0; i < 300; i++) begin
            rs1      = 5'($urandom_range(0, 3));
            rs2      = 5'($urandom_range(0, 3));
            rd1      = 5'($urandom_range(0, 3));
            uses1    = 1'($urandom_range(0, 1));
            uses2    = 1'($urandom_range(0, 1));
            is_store = 1'($urandom_range(0, 1));
            mem_read = 1'($urandom_range(0, 1));
            br       = ($urandom_range(0, 5) == 0);
            dreq     = ($urandom_range(0, 2) == 0);
            drdy     = 1'($urandom_range(0, 1));
            irdy     = ($urandom_range(0, 3) != 0);
            tick();
        end

        idle();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
